// File: rtl/digit_argmax_classifier_if.sv
// Bundles the layer-side inputs and the classification outputs of the argmax stage.
// The master drives the layer-side signals; the slave is the classifier.
interface digit_argmax_classifier_if #(
  parameter int N_CLASSES  = 10,
  parameter int SCORE_BITS = 24,
  parameter int IDX_BITS   = 4
) ();

  logic                   i_layer_done;
  logic signed [SCORE_BITS:0] i_scores [0:N_CLASSES-1];
  logic                   o_busy;
  logic                   o_result_valid;
  logic [IDX_BITS-1:0]    o_digit;
  logic signed [SCORE_BITS:0] o_max_score;

  modport master (
    output i_layer_done,
    output i_scores,
    input  o_busy,
    input  o_result_valid,
    input  o_digit,
    input  o_max_score
  );

  modport slave (
    input  i_layer_done,
    input  i_scores,
    output o_busy,
    output o_result_valid,
    output o_digit,
    output o_max_score
  );

endinterface

// File: rtl/digit_argmax_classifier.sv
// Snapshots the dense layer's scores on a rising layer_done and scans them one per
// clock, reporting the lowest index of the maximum signed score with a one-cycle pulse.
module digit_argmax_classifier #(
  parameter int N_CLASSES  = 10,
  parameter int SCORE_BITS = 24,
  parameter int IDX_BITS   = 4
) (
  input logic clk,
  input logic rst,
  digit_argmax_classifier_if.slave bus
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                       r_layer_done_q;
  logic signed [SCORE_BITS:0] r_bank [0:N_CLASSES-1];
  logic signed [SCORE_BITS:0] r_best_val;
  logic [IDX_BITS-1:0]        r_best_idx;
  logic [IDX_BITS-1:0]        r_idx;
  logic                       r_busy;
  logic                       r_result_valid;
  logic [IDX_BITS-1:0]        r_digit;
  logic signed [SCORE_BITS:0] r_max_score;

  logic w_start_evt;
  logic w_capture;
  logic w_scan;
  logic w_last;
  logic w_done;

  assign w_start_evt = bus.i_layer_done & ~r_layer_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_layer_done_q <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_layer_done_q <= bus.i_layer_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_start_evt) w_next_state = SCAN;
      SCAN:    if (r_idx == LAST_IDX) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == IDLE) && w_start_evt;
    w_scan    = (r_state == SCAN);
    w_last    = (r_idx == LAST_IDX);
    w_done    = (r_state == DONE);
  end

  // Strict '>' keeps the earlier index on ties; the bank isolates the scan from later input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CLASSES; i++) r_bank[i] <= '0;
      r_best_val     <= '0;
      r_best_idx     <= '0;
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_digit        <= '0;
      r_max_score    <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_capture) begin
        for (int i = 0; i < N_CLASSES; i++) r_bank[i] <= bus.i_scores[i];
        r_best_val <= bus.i_scores[0];
        r_best_idx <= '0;
        r_idx      <= IDX_BITS'(1);
        r_busy     <= 1'b1;
      end
      if (w_scan) begin
        if (r_bank[r_idx] > r_best_val) begin
          r_best_val <= r_bank[r_idx];
          r_best_idx <= r_idx;
        end
        if (!w_last) r_idx <= r_idx + IDX_BITS'(1);
      end
      if (w_done) begin
        r_digit        <= r_best_idx;
        r_max_score    <= r_best_val;
        r_result_valid <= 1'b1;
        r_busy         <= 1'b0;
      end
    end
  end

  assign bus.o_busy         = r_busy;
  assign bus.o_result_valid = r_result_valid;
  assign bus.o_digit        = r_digit;
  assign bus.o_max_score    = r_max_score;

endmodule

// File: tb/tb_digit_argmax_classifier.sv
// Directed and randomized checks of digit_argmax_classifier against an argmax
// reference model computed from the captured scores.
module tb_digit_argmax_classifier;

  localparam int N  = 10;
  localparam int SB = 24;
  localparam int IB = 4;

  typedef logic signed [SB:0] score_t;
  typedef score_t scoreArr_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  scoreArr_t expScores;
  int busyCycles;
  int pulses;
  int firstPulse;
  logic [IB-1:0] pulseDigit;
  score_t pulseMax;

  digit_argmax_classifier_if #(.N_CLASSES(N), .SCORE_BITS(SB), .IDX_BITS(IB)) bus ();

  digit_argmax_classifier #(.N_CLASSES(N), .SCORE_BITS(SB), .IDX_BITS(IB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Argmax from first principles: find the maximum value, then its first occurrence.
  function automatic void refModel(input scoreArr_t s, output int idx, output score_t mx);
    mx = s[0];
    foreach (s[i]) if (s[i] > mx) mx = s[i];
    idx = -1;
    for (int i = N - 1; i >= 0; i--) if (s[i] == mx) idx = i;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Produces a clean rising edge of layer_done with the given scores, driven at a falling edge.
  task automatic applyStimulus(input scoreArr_t s);
    bus.i_layer_done = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) bus.i_scores[i] = s[i];
    expScores = s;
    bus.i_layer_done = 1'b1;
  endtask

  // mode 1 scrambles scores at changeAt; mode 2 also re-pulses layer_done while busy.
  task automatic observeWindow(input int cycles, input int mode, input int changeAt);
    busyCycles = 0;
    pulses     = 0;
    firstPulse = -1;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (mode != 0 && cyc == changeAt) begin
        for (int i = 0; i < N; i++) bus.i_scores[i] = score_t'($urandom);
        if (mode == 2) bus.i_layer_done = 1'b0;
      end
      if (mode == 2 && cyc == changeAt + 1) bus.i_layer_done = 1'b1;
      @(negedge clk);
      if (bus.o_busy === 1'b1) busyCycles++;
      if (bus.o_result_valid === 1'b1) begin
        pulses++;
        if (firstPulse < 0) begin
          firstPulse = cyc;
          pulseDigit = bus.o_digit;
          pulseMax   = bus.o_max_score;
        end
      end
    end
  endtask

  task automatic checkRun(input string tag);
    int expIdx;
    score_t expMax;
    refModel(expScores, expIdx, expMax);
    checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'(N));
    checkOutput({tag, ".pulses"}, 64'(pulses), 64'd1);
    checkOutput({tag, ".latency"}, 64'(firstPulse), 64'(N));
    checkOutput({tag, ".digit"}, 64'(pulseDigit), 64'(expIdx));
    checkOutput({tag, ".maxScore"}, 64'(pulseMax), 64'(expMax));
    checkOutput({tag, ".digitHeld"}, 64'(bus.o_digit), 64'(expIdx));
    checkOutput({tag, ".maxHeld"}, 64'(bus.o_max_score), 64'(expMax));
  endtask

  task automatic runCase(input string tag, input scoreArr_t s);
    applyStimulus(s);
    observeWindow(N + 6, 0, 0);
    checkRun(tag);
  endtask

  initial begin
    scoreArr_t s;
    bus.i_layer_done = 1'b0;
    for (int i = 0; i < N; i++) bus.i_scores[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset.valid", 64'(bus.o_result_valid), 64'd0);
    checkOutput("reset.digit", 64'(bus.o_digit), 64'd0);
    checkOutput("reset.maxScore", 64'(bus.o_max_score), 64'd0);

    s = '{5, -3, 12, 0, 7, 1, 2, 40, -8, 9};
    runCase("basic", s);

    foreach (s[i]) s[i] = 10;
    s[2] = 100;
    s[5] = 100;
    runCase("tie", s);

    s = '{-50, -20, -7, -90, -7, -33, -100, -60, -8, -9};
    runCase("allNeg", s);

    foreach (s[i]) s[i] = score_t'(-(1 << 24));
    s[9] = score_t'((1 << 24) - 1);
    runCase("extremeLast", s);

    foreach (s[i]) s[i] = score_t'(-(1 << 24));
    s[0] = score_t'((1 << 24) - 1);
    s[4] = score_t'((1 << 24) - 2);
    runCase("extremeFirst", s);

    // layer_done held high for 40 cycles while inputs are scrambled after capture.
    s = '{3, 8, -1, 8, 0, 2, 7, 6, 5, 4};
    applyStimulus(s);
    observeWindow(40, 1, 2);
    checkRun("heldHigh");
    s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11};
    runCase("reRaise", s);

    // Reset asserted during the fourth scan cycle discards the classification.
    s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 77};
    applyStimulus(s);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.i_layer_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset.busy", 64'(bus.o_busy), 64'd0);
    checkOutput("midReset.valid", 64'(bus.o_result_valid), 64'd0);
    checkOutput("midReset.digit", 64'(bus.o_digit), 64'd0);
    checkOutput("midReset.maxScore", 64'(bus.o_max_score), 64'd0);
    observeWindow(20, 0, 0);
    checkOutput("midReset.pulses", 64'(pulses), 64'd0);
    checkOutput("midReset.busyCycles", 64'(busyCycles), 64'd0);
    s = '{-4, 6, 6, -9, 1, 0, 3, 2, 5, -1};
    runCase("afterReset", s);

    // A second rising edge while busy must be ignored.
    s = '{9, 1, 2, 3, 4, 5, 6, 7, 8, 0};
    applyStimulus(s);
    observeWindow(N + 10, 2, 3);
    checkRun("retrigger");

    for (int r = 0; r < 8; r++) begin
      foreach (s[i]) s[i] = score_t'($urandom);
      if (r % 2 == 0) s[$urandom_range(N - 1)] = s[$urandom_range(N - 1)];
      if (r % 4 == 1) foreach (s[i]) s[i] = score_t'($urandom_range(7)) - score_t'(3);
      runCase($sformatf("random%0d", r), s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/digit_argmax_classifier.md
Name: digit_argmax_classifier

Overview:
- Output stage placed directly downstream of the 10-neuron dense layer.
- On the rising edge of the layer's completion flag, it snapshots all 10 signed neuron outputs into a local register bank.
- It then scans the bank sequentially, one comparison per clock, to find the largest score, and presents the winning class index (predicted digit 0-9) with a one-cycle valid pulse.
- The result is held until the next classification completes.

Parameters:
- N_CLASSES, 10, number of neuron scores compared; legal range 2..16.
- SCORE_BITS, 24, MSB index of each signed score; each score is SCORE_BITS+1 bits wide.
- IDX_BITS, 4, width of the class index; must satisfy 2**IDX_BITS >= N_CLASSES.

Ports:
- clk, input, 1, single system clock; all logic is on the rising edge.
- rst, input, 1, reset: synchronous, active-high. One clock; reset is synchronous and active-high.
- layer_done, input, 1, completion flag from the upstream layer counter; a level signal that may stay high for many cycles.
- scores, input, array [0:N_CLASSES-1] of signed [SCORE_BITS:0], neuron outputs; sampled only on the capture cycle.
- busy, output, 1, high from the capture edge until the result edge.
- result_valid, output, 1, one-cycle pulse when digit and max_score update.
- digit, output, IDX_BITS, index of the maximum score.
- max_score, output, signed [SCORE_BITS:0], value of the maximum score.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: busy=0, result_valid=0, digit=0, max_score=0.
  - FSM goes to IDLE; scan index=0; score bank cleared.
  - layer_done history register cleared to 0, so a layer_done already high when rst deasserts counts as a rising edge.
  - Reset overrides everything, including mid-scan; the partial result is discarded.
- Edge detect: start_evt = layer_done & ~layer_done_q, where layer_done_q is registered every cycle in all states.
- FSM states and transitions:
  - IDLE: on start_evt, latch all scores into the bank, best_val<=scores[0], best_idx<=0, idx<=1, busy<=1, go to SCAN. Without start_evt, stay in IDLE.
  - SCAN, each cycle:
    - If bank[idx] > best_val (signed, strict), then best_val<=bank[idx] and best_idx<=idx.
    - If idx==N_CLASSES-1, go to DONE; otherwise idx<=idx+1.
  - DONE (one cycle): digit<=best_idx, max_score<=best_val, result_valid<=1, busy<=0, return to IDLE.
  - IDLE clears result_valid to 0, so the pulse lasts exactly one cycle.
- Latency:
  - Capture edge E0; comparisons on E1..E(N_CLASSES-1); outputs register at E(N_CLASSES).
  - result_valid is therefore high during the cycle after edge N_CLASSES (edge 10 for the default N_CLASSES=10).
  - busy is high for exactly N_CLASSES cycles.
- Comparison rules:
  - Fully signed two's-complement comparison.
  - Ties resolve to the lowest index, because the comparison is strict.
  - Scores are never truncated; best_val has the same width as a score.
- A new start_evt while busy=1 is ignored, with no queueing.
- Input changes after the capture cycle do not affect the result.
- digit and max_score hold their last value indefinitely; they change only in DONE or on reset.
- layer_done held high continuously produces exactly one classification. A new one requires layer_done to fall and rise again.
- A layer_done rising in the same cycle as DONE is captured on the following IDLE cycle only if it is still a rising edge there; it is otherwise lost. This is acceptable because the upstream counter reasserts layer_done per image.

Test Plan:
- Scores {5,-3,12,0,7,1,2,40,-8,9}, rising layer_done → busy for 10 cycles; then result_valid=1 for 1 cycle with digit=7, max_score=40.
- Tie: scores[2]=scores[5]=100, all others 10 → digit=2, max_score=100.
- All negative {-50,-20,-7,-90,-7,-33,-100,-60,-8,-9} → digit=2, max_score=-7. Also check the extremes: scores[9]=+(2^24-1) with the rest -2^24 → digit=9; scores[0] as the unique maximum → digit=0.
- layer_done held high for 40 cycles → exactly one result_valid pulse. Then drop layer_done for 1 cycle and raise it again → a second classification. Inputs changed after capture are ignored.
- Assert rst for 1 cycle during the 4th SCAN cycle → next cycle busy=0, result_valid=0, digit=0, max_score=0, no pulse follows. A fresh edge afterwards yields a correct result 10 cycles after capture.
- Second rising layer_done during busy (achieved by toggling) → ignored; only one pulse; result reflects the first capture.
